// File: rtl/avmm_if.sv
// Avalon-MM bursting bus bundle.
// Master drives the command/write side; slave returns wait/read data.
interface avmm_if #(
   parameter int AW  = 16,
   parameter int DW  = 64,
   parameter int BCW = 3
);
   logic [AW-1:0]   address;
   logic            read;
   logic            write;
   logic [BCW-1:0]  burstcount;
   logic [DW-1:0]   writedata;
   logic [DW/8-1:0] byteenable;
   logic            waitrequest;
   logic [DW-1:0]   readdata;
   logic            readdatavalid;

   modport master (
      output address, read, write, burstcount,
      output writedata, byteenable,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, burstcount,
      input  writedata, byteenable,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/avmm_burst_master.sv
// Avalon-MM burst master: one read or write burst per accepted command.
// Read beats pass straight through; write beats stream from wr_* handshake.
module avmm_burst_master #(
   parameter int AW        = 16,
   parameter int DW        = 64,
   parameter int MAX_BURST = 4,
   localparam int BCW      = $clog2(MAX_BURST) + 1
) (
   input  logic            clock,
   input  logic            reset_n,
   avmm_if.master          bus,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [AW-1:0]   cmd_address,
   input  logic [BCW-1:0]  cmd_burstcount,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [DW-1:0]   wr_data,
   input  logic [DW/8-1:0] wr_byteenable,
   output logic            rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic            done,
   output logic            error
);

   localparam int LSB = $clog2(DW/8);
   localparam logic [AW-1:0] AMASK =
      ~((AW'(1) << LSB) - AW'(1));

   typedef enum logic [1:0] {
      IDLE, RD_CMD, RD_DATA, WR_DATA
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [BCW-1:0] bc_q, bc_d;
   logic [BCW-1:0] cnt_q, cnt_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic           bc_bad;
   logic           last;

   assign bc_bad = (cmd_burstcount == '0) ||
                   (cmd_burstcount > BCW'(MAX_BURST));
   assign last   = (cnt_q == bc_q - BCW'(1));

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         bc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         bc_q    <= bc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      bc_d           = bc_q;
      cnt_d          = cnt_q;
      done_d         = 1'b0;
      err_d          = 1'b0;
      cmd_ready      = 1'b0;
      wr_ready       = 1'b0;
      rd_valid       = 1'b0;
      rd_data        = bus.readdata;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = addr_q;
      bus.burstcount = bc_q;
      bus.writedata  = wr_data;
      bus.byteenable = '1;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d = cmd_address & AMASK;
               bc_d   = cmd_burstcount;
               cnt_d  = '0;
               if (bc_bad) begin
                  err_d = 1'b1;
               end else if (cmd_write) begin
                  state_d = WR_DATA;
               end else begin
                  state_d = RD_CMD;
               end
            end
         end
         RD_CMD: begin
            bus.read = 1'b1;
            if (!bus.waitrequest) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.readdatavalid) begin
               rd_valid = 1'b1;
               cnt_d    = cnt_q + BCW'(1);
               if (last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WR_DATA: begin
            bus.write      = wr_valid;
            bus.byteenable = wr_byteenable;
            wr_ready       = !bus.waitrequest;
            if (wr_valid && !bus.waitrequest) begin
               cnt_d = cnt_q + BCW'(1);
               if (last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are forced quiet while reset is held, even before the first edge.
      if (!reset_n) begin
         cmd_ready = 1'b0;
         wr_ready  = 1'b0;
         rd_valid  = 1'b0;
         bus.read  = 1'b0;
         bus.write = 1'b0;
      end
   end

   assign done  = done_q & reset_n;
   assign error = err_q & reset_n;

endmodule
